// File: rtl/mux_master_router.sv
// One-master to two-slave request router. The target slave is decoded from
// addr_in[SEL_BIT] and locked for the whole transaction once it stalls.
module mux_master_router #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_BIT = ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              cmd_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              ack_in,
  output logic [DATA_W-1:0] rdata_in,
  output logic [ADDR_W-1:0] addr_out_first,
  output logic [DATA_W-1:0] wdata_out_first,
  output logic              cmd_out_first,
  output logic              req_out_first,
  input  logic              ack_out_first,
  input  logic [DATA_W-1:0] rdata_out_first,
  output logic [ADDR_W-1:0] addr_out_second,
  output logic [DATA_W-1:0] wdata_out_second,
  output logic              cmd_out_second,
  output logic              req_out_second,
  input  logic              ack_out_second,
  input  logic [DATA_W-1:0] rdata_out_second
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;
  logic   sel_q, sel_q_next;
  logic   sel;
  logic   sel_ack;
  logic   first_on, second_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else begin
      state <= state_next;
      sel_q <= sel_q_next;
    end
  end

  // The route follows the address only while idle; once busy it is frozen.
  assign sel     = (state == IDLE) ? addr_in[SEL_BIT] : sel_q;
  assign sel_ack = sel ? ack_out_second : ack_out_first;

  always_comb begin
    state_next = state;
    sel_q_next = sel_q;
    case (state)
      IDLE: begin
        if (req_in && !sel_ack) begin
          state_next = BUSY;
          sel_q_next = addr_in[SEL_BIT];
        end
      end
      BUSY: begin
        if (!req_in || sel_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced to zero while reset is held, independent of the clock.
  assign first_on  = rst_n && !sel;
  assign second_on = rst_n && sel;

  always_comb begin
    req_out_first    = first_on && req_in;
    addr_out_first   = first_on ? addr_in  : '0;
    wdata_out_first  = first_on ? wdata_in : '0;
    cmd_out_first    = first_on && cmd_in;
    req_out_second   = second_on && req_in;
    addr_out_second  = second_on ? addr_in  : '0;
    wdata_out_second = second_on ? wdata_in : '0;
    cmd_out_second   = second_on && cmd_in;
    ack_in           = rst_n && req_in && sel_ack;
    rdata_in         = '0;
    if (ack_in) rdata_in = sel ? rdata_out_second : rdata_out_first;
  end

endmodule

// File: tb/tb_mux_master_router.sv
// Directed bench for mux_master_router: reset, routing, lock, abort,
// back-to-back and mid-transfer reset.
module tb_mux_master_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_in;
  logic [31:0] addr_in;
  logic        cmd_in;
  logic [31:0] wdata_in;
  logic        ack_in;
  logic [31:0] rdata_in;
  logic [31:0] addr_out_first, wdata_out_first;
  logic        cmd_out_first, req_out_first, ack_out_first;
  logic [31:0] rdata_out_first;
  logic [31:0] addr_out_second, wdata_out_second;
  logic        cmd_out_second, req_out_second, ack_out_second;
  logic [31:0] rdata_out_second;

  int errors = 0;
  int checks = 0;

  mux_master_router dut (
    .clk(clk), .rst_n(rst_n),
    .req_in(req_in), .addr_in(addr_in), .cmd_in(cmd_in), .wdata_in(wdata_in),
    .ack_in(ack_in), .rdata_in(rdata_in),
    .addr_out_first(addr_out_first), .wdata_out_first(wdata_out_first),
    .cmd_out_first(cmd_out_first), .req_out_first(req_out_first),
    .ack_out_first(ack_out_first), .rdata_out_first(rdata_out_first),
    .addr_out_second(addr_out_second), .wdata_out_second(wdata_out_second),
    .cmd_out_second(cmd_out_second), .req_out_second(req_out_second),
    .ack_out_second(ack_out_second), .rdata_out_second(rdata_out_second)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic cmd,
                       input logic [31:0] wd, input logic a0, input logic [31:0] r0,
                       input logic a1, input logic [31:0] r1);
    req_in = req; addr_in = addr; cmd_in = cmd; wdata_in = wd;
    ack_out_first = a0; rdata_out_first = r0;
    ack_out_second = a1; rdata_out_second = r1;
    #1;
  endtask

  task automatic go_idle();
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    next_cycle();
    drive(1'b1, 32'hCE73_9CE7, 1'b1, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D);
    checks++; if (req_out_first !== 1'b0) begin errors++; $display("FAIL reset_req_first: got %b expected 0", req_out_first); end
    checks++; if (req_out_second !== 1'b0) begin errors++; $display("FAIL reset_req_second: got %b expected 0", req_out_second); end
    checks++; if (ack_in !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack_in); end
    checks++; if (rdata_in !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_in); end
    checks++; if (addr_out_second !== 32'h0) begin errors++; $display("FAIL reset_addr_second: got %h expected 0", addr_out_second); end
    checks++; if (wdata_out_second !== 32'h0) begin errors++; $display("FAIL reset_wdata_second: got %h expected 0", wdata_out_second); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    next_cycle();
    $display("test_reset done");
  endtask

  task automatic test_route_first();
    drive(1'b1, 32'h7FFF_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_1234, 1'b0, 32'h0);
    checks++; if (req_out_first !== 1'b1) begin errors++; $display("FAIL rf_req_first: got %b expected 1", req_out_first); end
    checks++; if (wdata_out_first !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rf_wdata_first: got %h expected ffffffff", wdata_out_first); end
    checks++; if (addr_out_first !== 32'h7FFF_0001) begin errors++; $display("FAIL rf_addr_first: got %h expected 7fff0001", addr_out_first); end
    checks++; if (cmd_out_first !== 1'b1) begin errors++; $display("FAIL rf_cmd_first: got %b expected 1", cmd_out_first); end
    checks++; if (req_out_second !== 1'b0) begin errors++; $display("FAIL rf_req_second: got %b expected 0", req_out_second); end
    checks++; if (wdata_out_second !== 32'h0) begin errors++; $display("FAIL rf_wdata_second: got %h expected 0", wdata_out_second); end
    checks++; if (ack_in !== 1'b1) begin errors++; $display("FAIL rf_ack: got %b expected 1", ack_in); end
    checks++; if (rdata_in !== 32'h0000_1234) begin errors++; $display("FAIL rf_rdata: got %h expected 00001234", rdata_in); end
    // Still IDLE: a new address must re-decode to the second slave right away.
    next_cycle();
    drive(1'b1, 32'hCE73_9CE7, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0000_0077);
    checks++; if (req_out_second !== 1'b1) begin errors++; $display("FAIL rf_stay_idle: got %b expected 1", req_out_second); end
    checks++; if (rdata_in !== 32'h0000_0077) begin errors++; $display("FAIL rf_rdata_second: got %h expected 00000077", rdata_in); end
    go_idle();
    $display("test_route_first done");
  endtask

  task automatic test_route_second();
    drive(1'b1, 32'hCE73_9CE7, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
    checks++; if (req_out_second !== 1'b1) begin errors++; $display("FAIL rs_req_second: got %b expected 1", req_out_second); end
    checks++; if (req_out_first !== 1'b0) begin errors++; $display("FAIL rs_req_first: got %b expected 0", req_out_first); end
    checks++; if (addr_out_second !== 32'hCE73_9CE7) begin errors++; $display("FAIL rs_addr_second: got %h expected ce739ce7", addr_out_second); end
    checks++; if (addr_out_first !== 32'h0) begin errors++; $display("FAIL rs_addr_first: got %h expected 0", addr_out_first); end
    checks++; if (ack_in !== 1'b1) begin errors++; $display("FAIL rs_ack: got %b expected 1", ack_in); end
    checks++; if (rdata_in !== 32'h0) begin errors++; $display("FAIL rs_rdata: got %h expected 0", rdata_in); end
    go_idle();
    $display("test_route_second done");
  endtask

  task automatic test_lock();
    drive(1'b1, 32'hCE73_9CE7, 1'b1, 32'h0000_00A5, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (req_out_second !== 1'b1) begin errors++; $display("FAIL lk_req_start: got %b expected 1", req_out_second); end
    next_cycle();
    drive(1'b1, 32'h56B5_AD6B, 1'b1, 32'h0000_00A5, 1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0);
    checks++; if (req_out_second !== 1'b1) begin errors++; $display("FAIL lk_req_second: got %b expected 1", req_out_second); end
    checks++; if (req_out_first !== 1'b0) begin errors++; $display("FAIL lk_req_first: got %b expected 0", req_out_first); end
    checks++; if (addr_out_second !== 32'h56B5_AD6B) begin errors++; $display("FAIL lk_addr_second: got %h expected 56b5ad6b", addr_out_second); end
    checks++; if (ack_in !== 1'b0) begin errors++; $display("FAIL lk_ack_ignored: got %b expected 0", ack_in); end
    checks++; if (rdata_in !== 32'h0) begin errors++; $display("FAIL lk_rdata_ignored: got %h expected 0", rdata_in); end
    drive(1'b1, 32'h56B5_AD6B, 1'b1, 32'h0000_00A5, 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h5555_5555);
    checks++; if (ack_in !== 1'b1) begin errors++; $display("FAIL lk_ack: got %b expected 1", ack_in); end
    checks++; if (rdata_in !== 32'h5555_5555) begin errors++; $display("FAIL lk_rdata: got %h expected 55555555", rdata_in); end
    next_cycle();
    drive(1'b1, 32'h56B5_AD6B, 1'b0, 32'h0, 1'b1, 32'h0000_0001, 1'b0, 32'h0);
    checks++; if (req_out_first !== 1'b1) begin errors++; $display("FAIL lk_release: got %b expected 1", req_out_first); end
    go_idle();
    $display("test_lock done");
  endtask

  task automatic test_abort();
    drive(1'b1, 32'hCE73_9CE7, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (req_out_second !== 1'b1) begin errors++; $display("FAIL ab_busy: got %b expected 1", req_out_second); end
    drive(1'b0, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (req_out_second !== 1'b0) begin errors++; $display("FAIL ab_drop_second: got %b expected 0", req_out_second); end
    checks++; if (req_out_first !== 1'b0) begin errors++; $display("FAIL ab_drop_first: got %b expected 0", req_out_first); end
    next_cycle();
    drive(1'b1, 32'h56B5_AD6B, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (req_out_first !== 1'b1) begin errors++; $display("FAIL ab_idle_next: got %b expected 1", req_out_first); end
    go_idle();
    $display("test_abort done");
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h7FFF_0001, 1'b0, 32'h0, 1'b1, 32'h0000_0011, 1'b0, 32'h0);
    checks++; if (ack_in !== 1'b1) begin errors++; $display("FAIL bb_ack_first: got %b expected 1", ack_in); end
    next_cycle();
    drive(1'b1, 32'h8000_0004, 1'b1, 32'h0000_0022, 1'b1, 32'h0000_0011, 1'b1, 32'h0000_0033);
    checks++; if (req_out_second !== 1'b1) begin errors++; $display("FAIL bb_req_second: got %b expected 1", req_out_second); end
    checks++; if (req_out_first !== 1'b0) begin errors++; $display("FAIL bb_req_first: got %b expected 0", req_out_first); end
    checks++; if (rdata_in !== 32'h0000_0033) begin errors++; $display("FAIL bb_rdata: got %h expected 00000033", rdata_in); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0011, 1'b1, 32'h0000_0033);
    checks++; if (ack_in !== 1'b0) begin errors++; $display("FAIL bb_ack_gated: got %b expected 0", ack_in); end
    go_idle();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'hCE73_9CE7, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h0000_0008, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++; if (req_out_second !== 1'b0) begin errors++; $display("FAIL rm_req_second: got %b expected 0", req_out_second); end
    checks++; if (req_out_first !== 1'b0) begin errors++; $display("FAIL rm_req_first: got %b expected 0", req_out_first); end
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (req_out_first !== 1'b1) begin errors++; $display("FAIL rm_idle_after: got %b expected 1", req_out_first); end
    go_idle();
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    test_reset();
    test_route_first();
    test_route_second();
    test_lock();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
